nic_rx_dma_ctrl: RTL
====================

# nic_rx_dma_ctrl

Receive-side DMA sequencer inserted between the core's memory/NIC access decoder and the data-memory and NIC ports of the processor tile. Once started, it polls the NIC input-status register, drains each received 64-bit packet from the NIC input buffer and writes it into data memory at an auto-incrementing word address. It stops after a programmed packet count. The processor keeps strict priority on both the memory port and the NIC port. The DMA only uses a port in cycles when the core is not requesting it.

## Interface
Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 64, data word width
- LEN_W, 8, packet-count width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cfg_start  in  1  one-cycle start pulse
- cfg_base  in  [0:ADDR_W-1]  first destination word address
- cfg_len  in  [0:LEN_W-1]  packets to transfer
- p_memEn, p_memWrEn  in  1 each  core memory request
- p_addr  in  [0:ADDR_W-1]  core address
- p_d_out  in  [0:DATA_W-1]  core store data
- p_nicEn, p_nicWrEn  in  1 each  core NIC request
- memEn, memWrEn  out  1 each  to data memory
- addr_out  out  [0:ADDR_W-1]  to data memory
- d_out  out  [0:DATA_W-1]  to data memory
- nicEn, nicWrEn  out  1 each  to NIC
- addr_nic  out  [0:1]  NIC register select
- dout_nic  in  [0:DATA_W-1]  NIC read data
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- rx_count  out  [0:LEN_W-1]  packets written so far

## Operation
- NIC register map: 00 = input buffer, 01 = input status. The valid flag is dout_nic[63].
- NIC reads are synchronous. Data appears on dout_nic in the cycle after nicEn=1 with nicWrEn=0.
- Port muxing:
  - Memory port: when p_memEn=1, memEn, memWrEn, addr_out and d_out come from the core. Otherwise they come from the DMA.
  - NIC port: when p_nicEn=1, the core drives nicEn and nicWrEn, and addr_nic = p_addr[30:31]. Otherwise the DMA drives them.
  - When neither side requests a port, all of that port's outputs are 0.
- FSM states:
  - IDLE: on cfg_start, load ptr=cfg_base, rem=cfg_len, clear rx_count. Go to FIN if cfg_len==0, else to POLL.
  - POLL: request nicEn=1, addr_nic=01. If the request is granted (p_nicEn=0), go to POLL_W; otherwise stay.
  - POLL_W: if dout_nic[63]=1, go to READ; else go to POLL.
  - READ: request nicEn=1, addr_nic=00. If granted, go to READ_W; otherwise stay.
  - READ_W: capture dout_nic into the data register, then go to WRITE.
  - WRITE: request memEn=1, memWrEn=1, addr_out=ptr, d_out=data register. If granted (p_memEn=0), do ptr+=1, rem-=1, rx_count+=1. Then go to FIN if rem==1 before the decrement, else to POLL. If not granted, stay.
  - FIN: done=1 for one cycle, then go to IDLE.
- busy=1 in every state except IDLE. cfg_start is ignored while busy=1.
- ptr wraps modulo 2^ADDR_W. rx_count never exceeds cfg_len.
- The DMA never asserts nicWrEn or drives a NIC address other than 00 or 01.
- Core access in a _W state does not disturb the capture: the dout_nic sampled there reflects the DMA's own prior request.

## Timing
- Reset state: IDLE, ptr=0, rem=0, data register=0, rx_count=0, busy=0, done=0. All port outputs 0 unless the core is driving them.
- Outputs other than the mux paths are registered. The mux from p_* to port outputs is combinational, with zero latency.
- Best-case transfer with no core contention and status already valid: 5 cycles per packet (POLL, POLL_W, READ, READ_W, WRITE). done rises 1 cycle after the last WRITE.
- Reset asserted mid-transfer: return to IDLE next edge with no done pulse. A memory write that was granted in the reset cycle is not retracted.
- cfg_start coincident with reset: reset wins.

## Structure
- A shared package holds:
  - The FSM state encoding (3 bits).
  - The NIC register addresses NIC_IN_BUF=2'b00 and NIC_IN_STAT=2'b01.
  - The status-bit index, 63.
- One sub-module, port_prio_mux: parameterized two-master priority mux, instantiated once for the memory port and once for the NIC port.

## Test plan
- Basic transfer: cfg_base=0x100, cfg_len=2, status valid immediately, NIC words 0xAAAA…, 0xBBBB… -> mem[0x100]=0xAAAA…, mem[0x101]=0xBBBB…, rx_count=2, done pulse at cycle 11 after start.
- Poll wait: status 0 for 4 polls, then 1 -> no memory write until status=1; addr_nic alternates 01 with no 00 reads before the valid flag.
- Core memory contention: p_memEn=1 held for 3 cycles during WRITE -> DMA write is delayed exactly 3 cycles; core address and data appear on the memory port in those cycles.
- Core NIC contention: p_nicEn=1 with p_addr[30:31]=10 during POLL -> addr_nic=10 that cycle; DMA retries next cycle; the packet is still written correctly.
- Zero length: cfg_len=0 -> busy for 1 cycle, done pulse, no nicEn or memEn from the DMA.
- Reset mid-transfer: reset in READ_W of packet 2 of 4 -> busy=0 and rx_count=0 next cycle, no done pulse; a new cfg_start then runs correctly.

Source files
------------

// File: rtl/nic_rx_dma_ctrl_pkg.sv
// Shared definitions for the NIC receive DMA sequencer.
// FSM encoding, NIC register map and status flag position.
package nic_rx_dma_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POLL   = 3'd1,
    S_POLL_W = 3'd2,
    S_READ   = 3'd3,
    S_READ_W = 3'd4,
    S_WRITE  = 3'd5,
    S_FIN    = 3'd6
  } state_e;

  localparam logic [1:0] NIC_IN_BUF  = 2'b00;
  localparam logic [1:0] NIC_IN_STAT = 2'b01;

  localparam int STAT_BIT = 63;

endpackage

// File: rtl/nic_rx_dma_ctrl_port_prio_mux.sv
// Two-master port mux: the core always wins, the DMA gets the
// port only in cycles the core leaves free; idle port drives zeros.
module port_prio_mux #(
  parameter int W = 1
) (
  input  logic         core_req_i,
  input  logic [W-1:0] core_bus_i,
  input  logic         dma_req_i,
  input  logic [W-1:0] dma_bus_i,
  output logic [W-1:0] bus_o,
  output logic         dma_gnt_o
);

  always_comb begin
    bus_o = '0;
    if (core_req_i) begin
      bus_o = core_bus_i;
    end else if (dma_req_i) begin
      bus_o = dma_bus_i;
    end
  end

  assign dma_gnt_o = ~core_req_i;

endmodule

// File: rtl/nic_rx_dma_ctrl.sv
// Receive DMA: polls NIC status, drains packets from the input
// buffer and stores them to data memory at an incrementing address.
module nic_rx_dma_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [0:ADDR_W-1] cfg_base,
  input  logic [0:LEN_W-1]  cfg_len,
  input  logic              p_memEn,
  input  logic              p_memWrEn,
  input  logic [0:ADDR_W-1] p_addr,
  input  logic [0:DATA_W-1] p_d_out,
  input  logic              p_nicEn,
  input  logic              p_nicWrEn,
  output logic              memEn,
  output logic              memWrEn,
  output logic [0:ADDR_W-1] addr_out,
  output logic [0:DATA_W-1] d_out,
  output logic              nicEn,
  output logic              nicWrEn,
  output logic [0:1]        addr_nic,
  input  logic [0:DATA_W-1] dout_nic,
  output logic              busy,
  output logic              done,
  output logic [0:LEN_W-1]  rx_count
);
  import nic_rx_dma_ctrl_pkg::*;

  localparam int MW = 2 + ADDR_W + DATA_W;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic       dma_mem_req;
  logic       dma_nic_req;
  logic [1:0] dma_nic_addr;
  logic       mem_gnt;
  logic       nic_gnt;
  logic [MW-1:0] mem_bus;
  logic [3:0]    nic_bus;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    dma_mem_req  = 1'b0;
    dma_nic_req  = 1'b0;
    dma_nic_addr = NIC_IN_BUF;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          ptr_d   = cfg_base;
          rem_d   = cfg_len;
          cnt_d   = '0;
          state_d = (cfg_len == '0) ? S_FIN : S_POLL;
        end
      end
      S_POLL: begin
        dma_nic_req  = 1'b1;
        dma_nic_addr = NIC_IN_STAT;
        if (nic_gnt) state_d = S_POLL_W;
      end
      S_POLL_W: begin
        state_d = dout_nic[STAT_BIT] ? S_READ : S_POLL;
      end
      S_READ: begin
        dma_nic_req  = 1'b1;
        dma_nic_addr = NIC_IN_BUF;
        if (nic_gnt) state_d = S_READ_W;
      end
      S_READ_W: begin
        data_d  = dout_nic;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        dma_mem_req = 1'b1;
        if (mem_gnt) begin
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          cnt_d   = cnt_q + LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? S_FIN : S_POLL;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  port_prio_mux #(.W(MW)) u_mem_mux (
    .core_req_i (p_memEn),
    .core_bus_i ({p_memEn, p_memWrEn, p_addr, p_d_out}),
    .dma_req_i  (dma_mem_req),
    .dma_bus_i  ({dma_mem_req, dma_mem_req, ptr_q, data_q}),
    .bus_o      (mem_bus),
    .dma_gnt_o  (mem_gnt)
  );

  // Core NIC register select comes from the two low address bits.
  port_prio_mux #(.W(4)) u_nic_mux (
    .core_req_i (p_nicEn),
    .core_bus_i ({p_nicEn, p_nicWrEn, p_addr[ADDR_W-2:ADDR_W-1]}),
    .dma_req_i  (dma_nic_req),
    .dma_bus_i  ({dma_nic_req, 1'b0, dma_nic_addr}),
    .bus_o      (nic_bus),
    .dma_gnt_o  (nic_gnt)
  );

  assign {memEn, memWrEn, addr_out, d_out} = mem_bus;
  assign {nicEn, nicWrEn, addr_nic}        = nic_bus;

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign rx_count = cnt_q;

endmodule
